// File: rtl/dequant_rr_scheduler.sv
// dequant_rr_scheduler
//   Time-shares one combinational dequantizer among NUM_REQ requesters.
//   Packets are granted round-robin; the requester's scale (max_num) is
//   latched at grant time and held for the whole grant. Each accepted beat
//   is sent through the external datapath (dq_data_in/dq_max_num ->
//   dq_data_out). The result is registered into a 2-entry FIFO, tagged
//   with the requester id and a last flag.
//   A grant ends on req_last or after BURST_LEN beats, whichever is first.
//
// Ports
//   clk, rst                 clock, async active-low reset
//   req_data/req_max_num     per-requester beat and scale (slice r = requester r)
//   req_valid/req_last       per-requester handshake, end of packet
//   req_ready                beat accepted when valid & ready (granted requester only)
//   dq_data_in, dq_max_num   operands to the shared dequantizer
//   dq_data_out              combinational dequantizer result
//   data_out*, data_out_id   FIFO head (data, tag, last), valid = non-empty
//   data_out_ready           downstream accept
//
// Optional: define DEQUANT_SCHEDULER_PERF_EN to add perf_beats (beats
//   accepted per requester) and perf_stall (granted-but-blocked cycles),
//   both 32-bit saturating.

`ifdef DEQUANT_SCHEDULER_PERF_EN
module dequant_rr_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 32'd1;
  end
endmodule
`endif

module dequant_rr_scheduler #(
  parameter int NUM_REQ       = 2,
  parameter int IN_WIDTH      = 32,
  parameter int BLOCK_SIZE    = 4,
  parameter int MAX_NUM_WIDTH = 32,
  parameter int OUT_WIDTH     = 16,
  parameter int BURST_LEN     = 8,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE*IN_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0][MAX_NUM_WIDTH-1:0]         req_max_num,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0]                            req_last,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [BLOCK_SIZE*IN_WIDTH-1:0]                dq_data_in,
  output logic [MAX_NUM_WIDTH-1:0]                      dq_max_num,
  input  logic [BLOCK_SIZE*OUT_WIDTH-1:0]               dq_data_out,
  output logic [BLOCK_SIZE*OUT_WIDTH-1:0]               data_out,
  output logic [ID_WIDTH-1:0]                           data_out_id,
  output logic                                          data_out_last,
  output logic                                          data_out_valid,
  input  logic                                          data_out_ready
`ifdef DEQUANT_SCHEDULER_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]                      perf_beats,
  output logic [31:0]                                   perf_stall
`endif
);
  localparam int OW = BLOCK_SIZE*OUT_WIDTH;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [OW-1:0]       data;
    logic [ID_WIDTH-1:0] id;
    logic                last;
  } ent_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] grant, rr_ptr, pick;
  logic [CW-1:0]       beat_cnt;
  logic [MAX_NUM_WIDTH-1:0] scale;
  logic                found, busy, accept, last_out;

  ent_t [1:0]          mem;
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count;
  logic                push, pop;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign busy     = (state == BUSY);
  // The burst cap forces last so the grant always releases within BURST_LEN beats.
  assign last_out = req_last[grant] | (beat_cnt == CW'(BURST_LEN-1));
  assign accept   = busy & req_valid[grant] & req_ready[grant];
  assign push     = accept;
  assign pop      = (count != 2'd0) & data_out_ready;

  always_comb begin
    req_ready = '0;
    // A full FIFO still takes a beat if its head drains this cycle.
    if (busy) req_ready[grant] = (count != 2'd2) | data_out_ready;
  end

  assign dq_data_in = busy ? req_data[grant] : '0;
  assign dq_max_num = scale;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)             state_nxt = BUSY;
      BUSY:    if (accept && last_out) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      scale    <= '0;
    end else begin
      state <= state_nxt;
      if (!busy && found) begin
        grant    <= pick;
        scale    <= req_max_num[pick];
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CW'(1);
        if (last_out)
          rr_ptr <= (int'(grant) == NUM_REQ-1) ? '0 : grant + ID_WIDTH'(1);
      end
    end
  end

  // 2-entry output FIFO; push at count 2 only happens alongside a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: dq_data_out, id: grant, last: last_out};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign data_out_valid = (count != 2'd0);
  assign data_out       = data_out_valid ? mem[rd_ptr].data : '0;
  assign data_out_id    = data_out_valid ? mem[rd_ptr].id   : '0;
  assign data_out_last  = data_out_valid & mem[rd_ptr].last;

`ifdef DEQUANT_SCHEDULER_PERF_EN
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_perf
    dequant_rr_sat_cnt u_beats (
      .clk (clk),
      .rst (rst),
      .inc (accept && (grant == ID_WIDTH'(r))),
      .cnt (perf_beats[r])
    );
  end
  dequant_rr_sat_cnt u_stall (
    .clk (clk),
    .rst (rst),
    .inc (busy & req_valid[grant] & ~req_ready[grant]),
    .cnt (perf_stall)
  );
`endif

endmodule
